instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
First pipeline stage of the MIPS core. Holds the PC and a word-addressed instruction memory that the debug/loader path writes. Fetches one instruction per enabled cycle and drives the IF/ID register (instruction, PC+4) that feeds instruction_decode. Reacts to the stall, jump and branch redirect that decode produces, and freezes itself on HALT.

Parameters:
MEM_DEPTH, 256, number of 32-bit instruction words
ADDR_W, 8, word-address width, equal to clog2(MEM_DEPTH)

Ports:
i_clk  in  1  clock; every register is updated on the rising edge
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  run/step enable from the debug unit; when 0 the PC and IF/ID register hold
i_stall  in  1  hazard-unit stall; holds the PC and IF/ID register
i_jump  in  1  redirect request from decode (jump, or branch taken)
i_jump_addr  in  32  byte address of the redirect target
i_write_en  in  1  instruction-memory write strobe from the loader
i_write_addr  in  ADDR_W  word index to write
i_write_data  in  32  instruction word to write
o_instruction  out  32  IF/ID instruction register
o_pc4  out  32  IF/ID PC+4 register
o_pc  out  32  current PC, for debug readout
o_halted  out  1  sticky flag: a HALT was issued

Behaviour:
- Reset values: pc=0, o_instruction=0 (NOP), o_pc4=0, o_halted=0. Instruction memory contents are not cleared.
- Fetch: fetched = mem[pc[ADDR_W+1:2]], read combinationally. pc[1:0] and the bits above ADDR_W+1 are ignored, so the word address wraps modulo MEM_DEPTH.
- A cycle "advances" when i_enable=1, i_stall=0 and o_halted=0.
- Advance without i_jump:
  - o_instruction <= fetched
  - o_pc4 <= pc+4
  - pc <= pc+4
- Advance with i_jump:
  - pc <= i_jump_addr
  - o_instruction <= 0. This flushes the wrong-path word; there is no delay slot.
  - o_pc4 <= pc+4
- Redirect latency: the target instruction appears on o_instruction 2 edges after i_jump is sampled.
- Priority, highest first: reset > not enabled / halted > i_stall > i_jump > sequential fetch.
  - i_jump is ignored while i_stall=1. Decode re-asserts it once the stall clears.
- HALT (fetched == 32'hFFFFFFFF during an advance with no jump):
  - o_instruction <= HALT, o_halted <= 1, pc unchanged.
  - Every later cycle holds all outputs until reset.
  - A HALT word on the flushed path (i_jump=1 in the same cycle) is discarded and does not set o_halted.
- Hold (no advance): pc, o_instruction and o_pc4 keep their values. Decode therefore sees the same instruction again.
- Memory writes:
  - Accepted on the edge only when i_write_en=1 and i_enable=0; ignored otherwise.
  - A write to the word currently addressed by pc is visible on the next fetch.
  - A write in the same cycle as reset is still performed.
- Reset in mid-run: state returns to the reset values on the next edge; program memory is kept, so the program can be re-run.

Decomposition:
- Shared package `mips_pkg`: INSTR_W=32, NOP=32'h0, HALT_INSTR=32'hFFFFFFFF, PC_STEP=4. Decode and the debug unit use the same package.
- One sub-module, `instruction_memory`: parameterised single-write-port, one-asynchronous-read-port RAM with ports (i_clk, i_we, i_waddr, i_wdata, i_raddr, o_rdata).
- The PC, hazard/priority logic and the IF/ID register stay in instruction_fetch.

Test Plan:
- Load and run:
  - Stimulus: with i_enable=0, write ADD, XORI, SW to words 0-2; release reset, set i_enable=1.
  - Required: on edges 1, 2, 3, o_instruction = ADD, XORI, SW and o_pc4 = 4, 8, 12.
- Stall:
  - Stimulus: assert i_stall for 2 cycles while o_instruction=XORI.
  - Required: o_instruction stays XORI and o_pc stays 8 during the stall; SW appears on the 1st edge after release.
- Jump:
  - Stimulus: i_jump=1, i_jump_addr=0x28 for one cycle while pc=8.
  - Required: next o_instruction=0 and o_pc=0x28; the edge after that gives o_instruction=mem[10], o_pc4=0x2C.
- Stall and jump together:
  - Stimulus: i_stall=1 and i_jump=1 in the same cycle.
  - Required: pc unchanged and no flush; the jump is taken only on the next cycle with i_stall=0.
- Halt:
  - Stimulus: word 3 = 0xFFFFFFFF.
  - Required: o_instruction=0xFFFFFFFF, o_halted=1, o_pc stays 12 for 5+ cycles. Then i_reset for 1 cycle gives pc=0, o_halted=0, and the program reruns from ADD.
- Write gating and wrap:
  - Stimulus: assert i_write_en with i_enable=1; then run with pc=0x400.
  - Required: the write is ignored (memory unchanged), and pc=0x400 fetches word 0.

Source files
------------

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Constants shared by the fetch, decode and debug blocks of the MIPS core.
//   INSTR_W    : instruction / datapath word width
//   NOP        : all-zero instruction, used for reset and redirect flushes
//   HALT_INSTR : all-ones word that stops the fetch stage
//   PC_STEP    : byte increment between sequential instructions
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP        = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hFFFF_FFFF;
    localparam logic [INSTR_W-1:0] PC_STEP    = 32'd4;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return (instr == HALT_INSTR);
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// ----------------------------------------------------------------------------
// instruction_memory
// Word-addressed RAM with one synchronous write port and one asynchronous
// read port. Contents are never reset so a loaded program survives a core
// reset.
// Ports:
//   i_clk   : clock
//   i_we    : write strobe (already gated by the caller)
//   i_waddr : word index to write
//   i_wdata : word to write
//   i_raddr : word index to read
//   o_rdata : combinational read data
// ----------------------------------------------------------------------------
module instruction_memory
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [INSTR_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [INSTR_W-1:0] o_rdata
);

    logic [INSTR_W-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
// First pipeline stage: PC register, instruction memory and IF/ID register.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_enable                : run/step enable; 0 holds the stage
//   i_stall                 : hazard stall; holds PC and IF/ID
//   i_jump, i_jump_addr     : redirect request and byte target from decode
//   i_write_en/addr/data    : loader write port (accepted only when idle)
//   o_instruction, o_pc4    : IF/ID register
//   o_pc                    : current PC for debug readout
//   o_halted                : sticky HALT flag
// ----------------------------------------------------------------------------
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [INSTR_W-1:0] i_jump_addr,
    input  logic               i_write_en,
    input  logic [ADDR_W-1:0]  i_write_addr,
    input  logic [INSTR_W-1:0] i_write_data,
    output logic [INSTR_W-1:0] o_instruction,
    output logic [INSTR_W-1:0] o_pc4,
    output logic [INSTR_W-1:0] o_pc,
    output logic               o_halted
);

    logic [INSTR_W-1:0] r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [INSTR_W-1:0] r_pc4;
    logic               r_halted;

    logic [INSTR_W-1:0] w_fetched;
    logic [INSTR_W-1:0] w_pc_next;
    logic               w_advance;
    logic               w_mem_we;

    // Loader may only write while the core is not running; reset does not
    // block it so a program can be loaded while the core is held in reset.
    assign w_mem_we = i_write_en & ~i_enable;

    instruction_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (i_write_addr),
        .i_wdata (i_write_data),
        .i_raddr (r_pc[ADDR_W+1:2]),   // byte PC -> word index, wraps at MEM_DEPTH
        .o_rdata (w_fetched)
    );

    assign w_pc_next = r_pc + PC_STEP;
    assign w_advance = i_enable & ~i_stall & ~r_halted;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc     <= '0;
            r_instr  <= NOP;
            r_pc4    <= '0;
            r_halted <= 1'b0;
        end else if (w_advance) begin
            r_pc4 <= w_pc_next;
            if (i_jump) begin
                // Wrong-path word is flushed; a HALT here is discarded too.
                r_pc    <= i_jump_addr;
                r_instr <= NOP;
            end else if (is_halt(w_fetched)) begin
                // PC stays on the HALT word; o_halted then blocks all advances.
                r_instr  <= HALT_INSTR;
                r_halted <= 1'b1;
            end else begin
                r_pc    <= w_pc_next;
                r_instr <= w_fetched;
            end
        end
    end

    assign o_instruction = r_instr;
    assign o_pc4         = r_pc4;
    assign o_pc          = r_pc;
    assign o_halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam logic [31:0] ADD  = 32'h0043_0820;
    localparam logic [31:0] XORI = 32'h38A6_000F;
    localparam logic [31:0] SW   = 32'hAC07_0004;
    localparam logic [31:0] W10  = 32'h2008_0005;
    localparam logic [31:0] W11  = 32'h0109_5022;
    localparam logic [31:0] HLT  = 32'hFFFF_FFFF;
    localparam logic [31:0] NEWW = 32'h0123_4567;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        stall;
    logic        jump;
    logic [31:0] jaddr;
    logic        we;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] pc;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    instruction_fetch #(.MEM_DEPTH(256), .ADDR_W(8)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (en),
        .i_stall       (stall),
        .i_jump        (jump),
        .i_jump_addr   (jaddr),
        .i_write_en    (we),
        .i_write_addr  (waddr),
        .i_write_data  (wdata),
        .o_instruction (instr),
        .o_pc4         (pc4),
        .o_pc          (pc),
        .o_halted      (halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_sb();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            assert (instr === e.instr) else begin
                n_fail++;
                $error("FAIL %s instr: observed %h expected %h", e.tag, instr, e.instr);
            end
            n_checks++;
            assert (pc4 === e.pc4) else begin
                n_fail++;
                $error("FAIL %s pc4: observed %h expected %h", e.tag, pc4, e.pc4);
            end
            n_checks++;
            assert (pc === e.pc) else begin
                n_fail++;
                $error("FAIL %s pc: observed %h expected %h", e.tag, pc, e.pc);
            end
            n_checks++;
            assert (halted === e.halted) else begin
                n_fail++;
                $error("FAIL %s halted: observed %b expected %b", e.tag, halted, e.halted);
            end
        end
    endtask

    // Push the expected post-edge state, advance one edge, sample 1 time unit later.
    task automatic step(input string tag, input logic [31:0] ei, input logic [31:0] ep4,
                        input logic [31:0] epc, input logic eh);
        exp_t e;
        e.tag = tag; e.instr = ei; e.pc4 = ep4; e.pc = epc; e.halted = eh;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_sb();
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; stall = 1'b0; jump = 1'b0; jaddr = '0;
        we = 1'b0; waddr = '0; wdata = '0;

        // Program is loaded while reset is held: writes must still land.
        load(8'd0, ADD);
        load(8'd1, XORI);
        load(8'd2, SW);
        load(8'd3, HLT);
        load(8'd10, W10);
        load(8'd11, W11);
        step("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        // Load and run
        rst = 1'b0; en = 1'b1;
        step("run1", ADD,  32'd4, 32'd4, 1'b0);
        step("run2", XORI, 32'd8, 32'd8, 1'b0);

        // Stall two cycles while XORI is in IF/ID
        stall = 1'b1;
        step("stall1", XORI, 32'd8, 32'd8, 1'b0);
        step("stall2", XORI, 32'd8, 32'd8, 1'b0);
        stall = 1'b0;
        step("unstall", SW, 32'd12, 32'd12, 1'b0);

        // Word 3 is HALT
        step("halt", HLT, 32'd16, 32'd12, 1'b1);
        for (int i = 0; i < 5; i++) begin
            jump = (i == 2); jaddr = 32'h28;
            step("halt_hold", HLT, 32'd16, 32'd12, 1'b1);
        end
        jump = 1'b0;

        // One-cycle reset, program reruns
        rst = 1'b1;
        step("rerun_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        step("rerun1", ADD,  32'd4, 32'd4, 1'b0);
        step("rerun2", XORI, 32'd8, 32'd8, 1'b0);

        // Stall and jump together: jump ignored, no flush
        stall = 1'b1; jump = 1'b1; jaddr = 32'h28;
        step("stall_jump", XORI, 32'd8, 32'd8, 1'b0);
        stall = 1'b0;
        step("jump", 32'h0, 32'd12, 32'h28, 1'b0);
        jump = 1'b0;
        step("jump_target", W10, 32'h2C, 32'h2C, 1'b0);
        step("after_target", W11, 32'h30, 32'h30, 1'b0);

        // Jump onto the HALT word, then redirect away: flushed HALT is discarded
        jump = 1'b1; jaddr = 32'h0C;
        step("jump_to_halt", 32'h0, 32'h34, 32'h0C, 1'b0);
        jaddr = 32'h400;
        step("flush_halt", 32'h0, 32'h10, 32'h400, 1'b0);
        jump = 1'b0;

        // pc=0x400 wraps to word 0; a write with enable=1 must be ignored
        step("wrap", ADD, 32'h404, 32'h404, 1'b0);
        we = 1'b1; waddr = 8'd2; wdata = JUNK;
        step("gated_write", XORI, 32'h408, 32'h408, 1'b0);
        we = 1'b0;
        step("mem_unchanged", SW, 32'h40C, 32'h40C, 1'b0);

        // Idle: outputs hold; write the word the pc points at (word 3)
        en = 1'b0;
        step("idle_hold", SW, 32'h40C, 32'h40C, 1'b0);
        we = 1'b1; waddr = 8'd3; wdata = NEWW;
        step("idle_write", SW, 32'h40C, 32'h40C, 1'b0);
        we = 1'b0; en = 1'b1;
        step("write_visible", NEWW, 32'h410, 32'h410, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
